adder_sum_accumulator: RTL and testbench
========================================

Name: adder_sum_accumulator

Overview:
- Downstream consumer of the 2-bit adder stage.
- Each accepted sample is the adder result {Carry,s1,s0}, an unsigned value 0..6. The block accumulates a programmed number of these samples into a wide saturating register.
- Controlled by a start/busy/done handshake; samples arrive over a valid/ready handshake.
- Feeds accumulated sums forward to later datapath and debug stages of the CPU build-up.

Parameters:
- ACC_W, 8: accumulator and result width in bits (≥3).
- CNT_W, 6: width of the sample-count field len.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a run; sampled only in IDLE.
- len  in  CNT_W  number of samples in the run; latched when start is accepted.
- in_valid  in  1  the adder-result sample is present this cycle.
- in_ready  out  1  the block accepts a sample this cycle.
- s0  in  1  adder sum bit 0.
- s1  in  1  adder sum bit 1.
- carry  in  1  adder carry-out; sample weight 4.
- acc_out  out  ACC_W  registered accumulated sum.
- overflow  out  1  sticky flag; set when saturation occurred during the current run.
- busy  out  1  high in ACCUM and DONE.
- done  out  1  one-cycle pulse; acc_out is final in this cycle.

Behaviour:
- Reset (reset_n==0 at a clock edge):
  - state goes to IDLE; remaining=0; acc_out=0; overflow=0; done=0; busy=0; in_ready=0.
  - Reset has priority over every other input, including mid-run; a partial sum is discarded.
- States: IDLE, ACCUM, DONE. Use a 2-bit encoding; the unused code goes to IDLE.
- IDLE:
  - in_ready=0, busy=0, done=0.
  - start=1 and len!=0: acc_out<=0, overflow<=0, remaining<=len, go to ACCUM.
  - start=1 and len==0: acc_out<=0, overflow<=0, go directly to DONE (empty run).
- ACCUM:
  - in_ready=1 (combinational, equal to state==ACCUM); busy=1.
  - A sample is accepted when in_valid && in_ready at the edge.
  - On accept: sample = {carry,s1,s0} zero-extended to ACC_W+1 bits; sum = acc_out + sample.
  - If sum[ACC_W]==1: acc_out<=all ones and overflow<=1 (saturate). Otherwise acc_out<=sum[ACC_W-1:0].
  - Once saturated, acc_out stays all ones for the rest of the run.
  - On accept, remaining<=remaining-1. If remaining==1 at that edge, go to DONE.
  - in_valid=0: no state change; gaps of any length are allowed.
  - start is ignored in this state.
- DONE:
  - done=1 and busy=1 for exactly one cycle; in_ready=0; start ignored.
  - Unconditionally go to IDLE.
- Latency: done is asserted in the cycle immediately after the final sample is accepted. For len==0, done is asserted in the cycle after start.
- acc_out and overflow hold their values through IDLE until the next accepted start clears them.
- s0, s1 and carry are don't-care unless in_valid && in_ready.

Decomposition:
- Shared package/include holds:
  - state encodings ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_DONE=2'd2;
  - SAMPLE_W=3, the width of the {carry,s1,s0} sample.
- One sub-module is natural: sat_add (ACC_W-bit accumulator plus 3-bit addend, outputs the saturated sum and an ovf flag). It is purely combinational.
- The FSM, down-counter and registers stay in the top module.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with start=1 and in_valid=1 → acc_out=0, overflow=0, busy=0, done=0, in_ready=0 throughout.
- Basic run: start with len=2; then samples {carry,s1,s0}=101 (5) and 110 (6) on consecutive cycles → in_ready=1 for 2 cycles, done pulses for 1 cycle immediately after the second accept, acc_out=11, overflow=0, busy returns to 0 on the next cycle.
- Gaps: len=3; three samples of 6 separated by 2-cycle in_valid=0 gaps → acc_out=18 at done; the gaps do not consume count.
- Saturation: default ACC_W=8, len=50, every sample 110 → acc_out=255 and overflow=1 at done; acc_out stays 255 after overflow.
- Empty run and ignored start: start with len=0 → done in the next cycle, acc_out=0. Pulsing start with len=5 while in ACCUM does not restart the run or reload the count.
- Mid-run reset: len=4; accept one sample of 3; then reset_n=0 for 1 cycle → IDLE, acc_out=0, no done pulse. A new start with len=1 and sample 4 → acc_out=4.

Source files
------------

// File: rtl/adder_sum_accumulator_pkg.sv
// Shared definitions for the adder-result accumulator.
// Holds the FSM encoding and the sample width.
package adder_sum_accumulator_pkg;

    localparam int SAMPLE_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/adder_sum_accumulator_sat_add.sv
// Saturating adder: ACC_W-bit accumulator plus a small sample.
// Clamps to all ones and raises ovf when the sum carries out.
module adder_sum_accumulator_sat_add
    import adder_sum_accumulator_pkg::*;
#(
    parameter int ACC_W = 8
) (
    input  logic [ACC_W-1:0]    acc,
    input  logic [SAMPLE_W-1:0] addend,
    output logic [ACC_W-1:0]    sum,
    output logic                ovf
);

    logic [ACC_W:0] wide;

    // Full-width add, then clamp on carry-out
    always_comb begin
        wide = {1'b0, acc} + (ACC_W+1)'(addend);
        ovf  = wide[ACC_W];
        sum  = wide[ACC_W] ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
    end

endmodule

// File: rtl/adder_sum_accumulator.sv
// Accumulates a programmed number of adder results {carry,s1,s0}
// into a saturating register under a start/busy/done handshake.
module adder_sum_accumulator
    import adder_sum_accumulator_pkg::*;
#(
    parameter int ACC_W = 8,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             s0,
    input  logic             s1,
    input  logic             carry,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    remaining;
    logic [SAMPLE_W-1:0] sample;
    logic [ACC_W-1:0]    sat_sum;
    logic                sat_ovf;
    logic                accept;
    logic                last;

    assign sample = {carry, s1, s0};
    assign accept = in_valid && in_ready;
    assign last   = (remaining == CNT_W'(1));

    adder_sum_accumulator_sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .acc    (acc_out),
        .addend (sample),
        .sum    (sat_sum),
        .ovf    (sat_ovf)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept && last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Accumulator, sticky overflow and sample down-counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_out   <= '0;
            overflow  <= 1'b0;
            remaining <= '0;
        end else if (state == ST_IDLE && start) begin
            acc_out   <= '0;
            overflow  <= 1'b0;
            remaining <= len;
        end else if (accept) begin
            acc_out   <= sat_sum;
            remaining <= remaining - CNT_W'(1);
            if (sat_ovf) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Randomized self-checking bench for adder_sum_accumulator.
// Expected sums come from plain integer arithmetic with clamping.
module tb_adder_sum_accumulator;

    localparam int ACC_W = 8;
    localparam int CNT_W = 6;
    localparam int MAXV  = (1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic             s0;
    logic             s1;
    logic             carry;
    logic [ACC_W-1:0] acc_out;
    logic             overflow;
    logic             busy;
    logic             done;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_sum = 0;

    always #5 clk = ~clk;

    adder_sum_accumulator #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .s0       (s0),
        .s1       (s1),
        .carry    (carry),
        .acc_out  (acc_out),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_acc();
        return (exp_sum > MAXV) ? MAXV : exp_sum;
    endfunction

    function automatic int exp_ovf();
        return (exp_sum > MAXV) ? 1 : 0;
    endfunction

    // All tasks begin and end 1 time unit after a rising edge.
    task automatic start_run(input int n);
        exp_sum = 0;
        start   = 1'b1;
        len     = CNT_W'(n);
        @(negedge clk);
        chk("idle_ready", 32'(in_ready), 0);
        chk("idle_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic gap_cycles(input int g, input bit poke);
        for (int i = 0; i < g; i++) begin
            in_valid = 1'b0;
            {carry, s1, s0} = 3'($urandom_range(7));
            if (poke) begin
                start = 1'b1;
                len   = CNT_W'(5);
            end
            @(negedge clk);
            chk("gap_ready", 32'(in_ready), 1);
            chk("gap_done", 32'(done), 0);
            chk("gap_acc", 32'(acc_out), exp_acc());
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    task automatic send(input int v);
        in_valid = 1'b1;
        {carry, s1, s0} = 3'(v);
        @(negedge clk);
        chk("acc_ready", 32'(in_ready), 1);
        chk("acc_busy", 32'(busy), 1);
        chk("acc_done", 32'(done), 0);
        chk("acc_run", 32'(acc_out), exp_acc());
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_sum += v;
    endtask

    task automatic finish_check(input string tag);
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_busy"}, 32'(busy), 1);
        chk({tag, "_ready"}, 32'(in_ready), 0);
        chk({tag, "_acc"}, 32'(acc_out), exp_acc());
        chk({tag, "_ovf"}, 32'(overflow), exp_ovf());
        @(posedge clk);
        #1;
        @(negedge clk);
        chk({tag, "_done_off"}, 32'(done), 0);
        chk({tag, "_busy_off"}, 32'(busy), 0);
        chk({tag, "_hold"}, 32'(acc_out), exp_acc());
        @(posedge clk);
        #1;
    endtask

    // val < 0 picks a random sample, gap < 0 a random gap.
    task automatic run(input string tag, input int n, input int val,
                       input int gap, input bit poke);
        int v;
        int g;
        start_run(n);
        for (int k = 0; k < n; k++) begin
            g = (gap < 0) ? $urandom_range(3) : gap;
            gap_cycles(g, poke && k == 0);
            v = (val < 0) ? $urandom_range(6) : val;
            send(v);
        end
        finish_check(tag);
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b1;
        len      = CNT_W'(3);
        in_valid = 1'b1;
        {carry, s1, s0} = 3'b111;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_acc", 32'(acc_out), 0);
            chk("rst_ovf", 32'(overflow), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_ready", 32'(in_ready), 0);
            @(posedge clk);
            #1;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        reset_n  = 1'b1;
        @(posedge clk);
        #1;

        start_run(2);
        send(5);
        send(6);
        finish_check("basic");
        chk("basic_sum", 32'(exp_sum), 11);

        run("gaps", 3, 6, 2, 1'b0);
        chk("gaps_sum", 32'(exp_sum), 18);

        run("sat", 50, 6, 0, 1'b0);
        chk("sat_ovf_set", 32'(overflow), 1);

        run("empty", 0, 0, 0, 1'b0);
        run("poke", 3, -1, 2, 1'b1);

        start_run(4);
        send(3);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_done", 32'(done), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_acc", 32'(acc_out), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done2", 32'(done), 0);
        @(posedge clk);
        #1;
        start_run(1);
        send(4);
        finish_check("after_rst");

        for (int r = 0; r < 20; r++) begin
            run("rand", $urandom_range(12), -1, -1, $urandom_range(1) == 1);
        end
        run("rand_sat", 60, -1, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
